// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, 16x oversampled, with glitch rejection and framing-error detection
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  output logic [DBIT-1:0] rd_data,
  output logic            rx_done,
  output logic            frame_err,
  output logic            busy
);
  localparam int CW = $clog2(DVSR);
  localparam int NW = DBIT > 1 ? $clog2(DBIT) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t          state_q;
  logic [1:0]      sync_q;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      s_q;
  logic [NW-1:0]   n_q;
  logic [DBIT-1:0] b_q;
  logic            rx_s, s_tick;
  assign rx_s   = sync_q[1];
  assign s_tick = cnt_q == CW'(DVSR - 1);
  assign busy   = state_q != IDLE;
  // divider free-runs so frame timing is only ever quantised to one tick
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= 2'b11;
      cnt_q     <= '0;
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      rd_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx};
      cnt_q     <= s_tick ? '0 : cnt_q + 1'b1;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            s_q     <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_q == 4'd7) begin
              if (!rx_s) begin
                s_q     <= '0;
                n_q     <= '0;
                state_q <= DATA;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_q == 4'd15) begin
              s_q <= '0;
              b_q <= {rx_s, b_q[DBIT-1:1]};
              if (n_q == NW'(DBIT - 1)) state_q <= STOP;
              else n_q <= n_q + 1'b1;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s_q == 4'(SB_TICK - 1)) begin
              state_q <= rx_s ? IDLE : BRK;
              if (rx_s) begin
                rd_data <= b_q;
                rx_done <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        BRK: begin
          if (rx_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed 8N1 frames checked against a byte/latency reference model
module tb_uart_rx;
  localparam int BT = 64;
  logic clk = 1'b0, reset = 1'b1, rx = 1'b1;
  logic [7:0] rd_data;
  logic rx_done, frame_err, busy;
  int checks = 0, errors = 0, cyc = 0;
  int fe_cnt = 0, both_cnt = 0, busy_bad = 0;
  logic [7:0] got_q[$], exp_q[$];
  int got_t[$], edge_t[$];
  logic [7:0] last_good = 8'h00;
  uart_rx #(.DBIT(8), .SB_TICK(16), .DVSR(4)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rd_data(rd_data),
    .rx_done(rx_done), .frame_err(frame_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (rx_done) begin
      got_q.push_back(rd_data);
      got_t.push_back(cyc);
      if (busy) busy_bad++;
    end
    if (frame_err) fe_cnt++;
    if (rx_done && frame_err) both_cnt++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] d, input logic stop);
    if (stop) begin
      exp_q.push_back(d);
      edge_t.push_back(cyc);
    end
    rx = 1'b0;
    repeat (BT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BT) @(negedge clk);
    end
    rx = stop;
    repeat (BT) @(negedge clk);
    rx = 1'b1;
  endtask
  // strobe lands ~9.5 bit times (608 clocks) after the start edge, plus sync and tick phase
  task automatic flush(input string tag);
    logic [7:0] g, e;
    int t, et;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      t = got_t.pop_front();
      et = edge_t.pop_front();
      check({tag, "_data"}, g, e);
      check({tag, "_lat"}, (t - et >= 604) && (t - et <= 616), 1);
      last_good = e;
    end
    got_q.delete(); got_t.delete(); exp_q.delete(); edge_t.delete();
    check({tag, "_rd_data"}, rd_data, last_good);
  endtask
  initial begin
    int fe0, sp;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_rx_done", rx_done, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    idle(20);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    idle(100);
    flush("glitch");
    check("glitch_busy", busy, 0);
    send(8'hA5, 1'b1);
    idle(BT);
    flush("good");
    check("good_busy", busy, 0);
    fe0 = fe_cnt;
    send(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (3 * BT) @(negedge clk);
    check("ferr_pulses", fe_cnt - fe0, 1);
    check("ferr_break_busy", busy, 1);
    flush("ferr_low");
    idle(BT);
    check("ferr_idle_busy", busy, 0);
    send(8'h5A, 1'b1);
    idle(BT);
    check("ferr_after_pulses", fe_cnt - fe0, 1);
    flush("ferr_next");
    send(8'h05, 1'b1);
    send(8'h03, 1'b1);
    send(8'h20, 1'b1);
    idle(BT);
    if (got_t.size() >= 3) begin
      sp = got_t[1] - got_t[0];
      check("b2b_gap1", sp >= 636 && sp <= 644, 1);
      sp = got_t[2] - got_t[1];
      check("b2b_gap2", sp >= 636 && sp <= 644, 1);
    end
    flush("b2b");
    rx = 1'b0;
    repeat (BT) @(negedge clk);
    rx = 1'b1;
    repeat (4 * BT + BT / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_good = 8'h00;
    check("mrst_rd_data", rd_data, 8'h00);
    check("mrst_rx_done", rx_done, 0);
    check("mrst_frame_err", frame_err, 0);
    check("mrst_busy", busy, 0);
    fe0 = fe_cnt;
    idle(BT / 2 + 4 * BT);
    flush("mrst_abort");
    send(8'h81, 1'b1);
    idle(BT);
    flush("mrst_next");
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    idle(BT);
    check("edge_no_ferr", fe_cnt - fe0, 0);
    flush("edge");
    for (int k = 0; k < 16; k++) begin
      send(8'($urandom), 1'b1);
      idle($urandom_range(0, 100));
    end
    idle(BT);
    flush("rand");
    check("never_both", both_cnt, 0);
    check("busy_at_strobe", busy_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
